// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stage and FSM encodings shared by the pipeline control unit
package pipe_ctrl_pkg;
    localparam int N_STAGES = 5;
    localparam logic [1:0] RUN_ENC = 2'd0;
    localparam logic [1:0] MDIV_ENC = 2'd1;
    localparam logic [1:0] TRAPH_ENC = 2'd2;
    typedef enum logic [2:0] {ST_F, ST_D, ST_E, ST_M, ST_W} stage_t;
    typedef enum logic [1:0] {RUN = RUN_ENC, MDIV = MDIV_ENC, TRAPH = TRAPH_ENC} pc_state_t;
    function automatic logic [N_STAGES-1:0] stall_upto(stage_t s);
        logic [N_STAGES-1:0] m;
        for (int i = 0; i < N_STAGES; i++) m[i] = i <= int'(s);
        return m;
    endfunction
endpackage

// File: rtl/pipe_ctrl_stall_mask.sv
// pc_stall_mask: priority-encodes stall sources to the deepest held stage and expands it
module pc_stall_mask
    import pipe_ctrl_pkg::*;
(
    input  pc_state_t             st,
    input  logic                  trap,
    input  logic                  imem_wait,
    input  logic                  ld_use,
    input  logic                  mdiv_start,
    input  logic                  mdiv_done,
    input  logic                  dmem_wait,
    output logic [N_STAGES-1:0]   mask
);
    logic   mdiv_busy;
    logic   hit;
    stage_t top;
    assign mdiv_busy = st == MDIV && !mdiv_done;
    assign hit = !trap && (st == TRAPH || mdiv_busy || dmem_wait || (st == RUN && mdiv_start)
                           || ld_use || imem_wait);
    // A completing mul/div releases E, so that cycle falls back to the ordinary hazards.
    assign top = st == TRAPH ? ST_F
               : mdiv_busy ? (dmem_wait ? ST_M : ST_E)
               : dmem_wait ? ST_M
               : (st == RUN && mdiv_start) ? ST_E
               : ld_use ? ST_D
               : ST_F;
    assign mask = hit ? stall_upto(top) : '0;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush generator for the RV32 pipeline, sequencing
// traps, multi-cycle mul/div and fetch redirects through a small FSM.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N_ST     = N_STAGES,
    parameter int TRAP_CYC = 2,
    parameter int MDIV_MAX = 40
) (
    input  logic       clk,
    input  logic       grst,
    input  logic       imem_wait,
    input  logic       ld_use,
    input  logic       redirect,
    input  logic       mdiv_start,
    input  logic       mdiv_done,
    input  logic       dmem_wait,
    input  logic       trap,
    output logic       stall [N_ST-1:0],
    output logic       flush [N_ST-1:0],
    output logic [1:0] state_o,
    output logic       err
);
    localparam int CW = $clog2(MDIV_MAX + 1);
    localparam int TW = $clog2(TRAP_CYC + 2);
    localparam logic [CW-1:0] MDIV_LIM = CW'(MDIV_MAX);
    localparam logic [TW-1:0] TRAP_LIM = TW'(TRAP_CYC);
    pc_state_t           state, state_nx;
    logic [CW-1:0]       mdiv_cnt, mdiv_inc, mdiv_nx;
    logic [TW-1:0]       trap_cnt, trap_nx;
    logic                redir_pend, pend_nx, redir_ok, pend_fire, enter_mdiv, timeout;
    logic [N_STAGES-1:0] mask;
    logic [N_ST-1:0]     stall_v, flush_v;

    pc_stall_mask u_mask (
        .st         (state),
        .trap       (trap),
        .imem_wait  (imem_wait),
        .ld_use     (ld_use),
        .mdiv_start (mdiv_start),
        .mdiv_done  (mdiv_done),
        .dmem_wait  (dmem_wait),
        .mask       (mask)
    );

    // A mul/div only starts once nothing deeper holds E.
    assign enter_mdiv = !trap && state == RUN && mdiv_start && !dmem_wait;
    assign mdiv_inc = mdiv_cnt == MDIV_LIM ? mdiv_cnt : mdiv_cnt + 1'b1;
    assign timeout = !trap && state == MDIV && !mdiv_done && mdiv_inc == MDIV_LIM;
    assign mdiv_nx = enter_mdiv ? '0 : state == MDIV ? mdiv_inc : mdiv_cnt;
    assign trap_nx = trap ? TRAP_LIM
                   : (state == TRAPH && trap_cnt != '0) ? trap_cnt - 1'b1
                   : trap_cnt;
    assign state_nx = trap ? TRAPH
                    : state == RUN ? (enter_mdiv ? MDIV : RUN)
                    : state == MDIV ? ((mdiv_done || timeout) ? RUN : MDIV)
                    : trap_cnt <= TW'(1) ? RUN : TRAPH;
    assign redir_ok = !trap && state == RUN && redirect && !mask[ST_E];
    // The fetch outstanding at redirect time returns stale; drop it when it lands.
    assign pend_fire = !trap && redir_pend && !imem_wait;
    assign pend_nx = !trap && imem_wait && (redir_pend || redir_ok);

    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            state      <= RUN;
            mdiv_cnt   <= '0;
            trap_cnt   <= '0;
            redir_pend <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            mdiv_cnt   <= mdiv_nx;
            trap_cnt   <= trap_nx;
            redir_pend <= pend_nx;
            err        <= err | timeout;
        end
    end

    assign stall_v = grst ? '0 : N_ST'(mask);
    assign flush_v = grst ? {N_ST{1'b1}}
                   : N_ST'(trap ? 4'hF : {2'b00, redir_ok, redir_ok | pend_fire});
    assign state_o = state;

    for (genvar g = 0; g < N_ST; g++) begin : g_out
        assign stall[g] = stall_v[g];
        assign flush[g] = flush_v[g];
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic grst, imem_wait, ld_use, redirect, mdiv_start, mdiv_done, dmem_wait, trap;
    logic stall [4:0], flush [4:0], stall4 [4:0], flush4 [4:0];
    logic [1:0] state_o, state4;
    logic err, err4;
    logic [4:0] obs_st, obs_fl;
    int checks = 0, errors = 0, n;

    // model: mode 0=run 1=mdiv 2=trap hold
    int m_mode = 0, m_left = 0, m_busy = 0;
    bit m_pend = 0, m_err = 0;

    localparam int TRAP_CYC = 2;
    localparam int MAXC = 40;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .grst(grst), .imem_wait(imem_wait), .ld_use(ld_use), .redirect(redirect),
        .mdiv_start(mdiv_start), .mdiv_done(mdiv_done), .dmem_wait(dmem_wait), .trap(trap),
        .stall(stall), .flush(flush), .state_o(state_o), .err(err)
    );

    pipe_ctrl #(.MDIV_MAX(4)) dut4 (
        .clk(clk), .grst(grst), .imem_wait(imem_wait), .ld_use(ld_use), .redirect(redirect),
        .mdiv_start(mdiv_start), .mdiv_done(mdiv_done), .dmem_wait(dmem_wait), .trap(trap),
        .stall(stall4), .flush(flush4), .state_o(state4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        {grst, imem_wait, ld_use, redirect, mdiv_start, mdiv_done, dmem_wait, trap} = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cycle;
        int deep;
        bit rtk, mono;
        logic [4:0] est, efl;
        #1;
        for (int i = 0; i < 5; i++) begin
            obs_st[i] = stall[i];
            obs_fl[i] = flush[i];
        end
        rtk = 0;
        if (grst) begin
            deep = -1;
            efl = 5'h1F;
        end else if (trap) begin
            deep = -1;
            efl = 5'h0F;
        end else begin
            if (m_mode == 2) deep = 0;
            else if (m_mode == 1 && !mdiv_done) deep = dmem_wait ? 3 : 2;
            else if (dmem_wait) deep = 3;
            else if (m_mode == 0 && mdiv_start) deep = 2;
            else if (ld_use) deep = 1;
            else if (imem_wait) deep = 0;
            else deep = -1;
            rtk = m_mode == 0 && redirect && deep < 2;
            efl = {3'b000, rtk, rtk || (m_pend && !imem_wait)};
        end
        for (int i = 0; i < 5; i++) est[i] = i <= deep;
        chk("stall", obs_st, est);
        chk("flush", obs_fl, efl);
        chk("state", state_o, grst ? 0 : m_mode);
        chk("err", err, grst ? 0 : m_err);
        mono = 1;
        for (int i = 1; i < 5; i++) if (obs_st[i] && !obs_st[i-1]) mono = 0;
        chk("monotone", mono, 1);
        chk("stall_w", obs_st[4], 0);
        @(posedge clk);
        if (grst) begin
            m_mode = 0; m_left = 0; m_busy = 0; m_pend = 0; m_err = 0;
        end else if (trap) begin
            m_mode = 2; m_left = TRAP_CYC; m_pend = 0;
        end else begin
            m_pend = imem_wait && (m_pend || rtk);
            if (m_mode == 0) begin
                if (mdiv_start && !dmem_wait) begin m_mode = 1; m_busy = 0; end
            end else if (m_mode == 1) begin
                m_busy = m_busy + 1 > MAXC ? MAXC : m_busy + 1;
                if (mdiv_done) m_mode = 0;
                else if (m_busy == MAXC) begin m_err = 1; m_mode = 0; end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        grst = 1;
        @(negedge clk);
        cycle();
        chk("reset_flush", obs_fl, 5'h1F);
        grst = 0;
        cycle();
        // reset asserted part-way through a mul/div
        mdiv_start = 1; cycle(); mdiv_start = 0;
        repeat (7) cycle();
        chk("mdiv_state", state_o, 1);
        grst = 1; cycle();
        chk("rst_mid_flush", obs_fl, 5'h1F);
        chk("rst_mid_stall", obs_st, 0);
        grst = 0; cycle();
        chk("rel_flush", obs_fl, 0);
        // load-use bubble
        ld_use = 1; cycle(); chk("ld_stall", obs_st, 5'b00011);
        ld_use = 0; cycle(); chk("ld_clear", obs_st, 0);
        // mul/div held then completed
        mdiv_start = 1; cycle(); n = int'(obs_st[2]); mdiv_start = 0;
        repeat (5) begin cycle(); n += int'(obs_st[2]); end
        mdiv_done = 1; cycle(); n += int'(obs_st[2]); mdiv_done = 0;
        cycle();
        chk("mdiv_e_cycles", n, 6);
        chk("mdiv_back_run", state_o, 0);
        // watchdog on the short-limit instance
        grst = 1; cycle(); grst = 0;
        mdiv_start = 1; cycle(); mdiv_start = 0;
        repeat (3) cycle();
        chk("err4_early", err4, 0);
        cycle();
        chk("err4_set", err4, 1);
        chk("err4_run", state4, 0);
        repeat (3) cycle();
        chk("err4_sticky", err4, 1);
        mdiv_done = 1; cycle(); mdiv_done = 0;
        // redirect while a fetch is outstanding
        redirect = 1; imem_wait = 1; cycle(); chk("rd_c0", obs_fl, 5'b00011);
        redirect = 0; cycle(); chk("rd_c1", obs_fl, 0);
        cycle(); chk("rd_c2", obs_fl, 0);
        imem_wait = 0; cycle(); chk("rd_c3", obs_fl, 5'b00001);
        cycle(); chk("rd_c4", obs_fl, 0);
        // trap overriding a data-memory stall
        trap = 1; dmem_wait = 1; cycle();
        chk("trap_flush", obs_fl, 5'b01111);
        chk("trap_stall", obs_st, 0);
        trap = 0; dmem_wait = 0; n = 0;
        repeat (4) begin cycle(); n += int'(obs_st[0]); end
        chk("trap_hold", n, TRAP_CYC);
        // randomized traffic
        repeat (10000) begin
            grst       = $urandom_range(0, 511) == 0;
            trap       = $urandom_range(0, 63) == 0;
            imem_wait  = $urandom_range(0, 3) == 0;
            ld_use     = $urandom_range(0, 5) == 0;
            redirect   = $urandom_range(0, 7) == 0;
            mdiv_start = $urandom_range(0, 9) == 0;
            mdiv_done  = $urandom_range(0, 11) == 0;
            dmem_wait  = $urandom_range(0, 4) == 0;
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
